// File: rtl/sat_add_pipe.sv
// Saturating signed adder with a one-entry valid/ready output stage, an
// accumulator feedback path and a sticky overflow event counter.
// Optional subtract mode is enabled by defining SAT_ADD_SUB_EN (adds port 'sub').
module sat_add_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  input  logic             acc,
  input  logic             clr,
`ifdef SAT_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             ovf,
  output logic [CNT_W-1:0] ovf_cnt
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH-1:0] low_sum;
  logic [WIDTH:0]   full_sum;
  logic             carry_msb;
  logic             sum_ovf;
  logic [WIDTH-1:0] sat_sum;
  logic             transfer;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Subtraction is done as opA + ~b + 1 so one adder and one overflow rule serve both modes.
  always_comb begin
    op_a    = acc ? acc_reg : a;
    b_eff   = b;
    cin_eff = Cin;
`ifdef SAT_ADD_SUB_EN
    if (sub) begin
      b_eff   = ~b;
      cin_eff = 1'b1;
    end
`endif
  end

  always_comb begin
    low_sum   = {1'b0, op_a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin_eff};
    full_sum  = {1'b0, op_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    carry_msb = low_sum[WIDTH-1];
    sum_ovf   = carry_msb ^ full_sum[WIDTH];
    if (sum_ovf)
      sat_sum = op_a[WIDTH-1] ? MIN_NEG : MAX_POS;
    else
      sat_sum = full_sum[WIDTH-1:0];
  end

  assign out_valid = (state == FULL);
  assign in_ready  = !out_valid || out_ready;
  assign transfer  = in_valid && in_ready;

  always_comb begin
    state_next = state;
    if (transfer)
      state_next = FULL;
    else if (out_ready)
      state_next = EMPTY;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      state <= EMPTY;
    else
      state <= state_next;
  end

  // Output registers only move on a transfer, so a stalled beat stays stable.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Result <= '0;
      Cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (transfer) begin
      Result <= sat_sum;
      Cout   <= full_sum[WIDTH];
      ovf    <= sum_ovf;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)
      acc_reg <= '0;
    else if (clr)
      acc_reg <= '0;
    else if (transfer)
      acc_reg <= sat_sum;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      ovf_cnt <= '0;
    else if (transfer && sum_ovf && (ovf_cnt != {CNT_W{1'b1}}))
      ovf_cnt <= ovf_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_sat_add_pipe.sv
// Directed self-checking bench for sat_add_pipe (WIDTH=4, CNT_W=8); subtract
// vectors are exercised only when SAT_ADD_SUB_EN is defined.
module tb_sat_add_pipe;

  logic       CLK = 1'b0;
  logic       RST;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       Cin;
  logic       acc;
  logic       clr;
`ifdef SAT_ADD_SUB_EN
  logic       sub;
`endif
  logic       out_valid;
  logic       out_ready;
  logic [3:0] Result;
  logic       Cout;
  logic       ovf;
  logic [7:0] ovf_cnt;

  int testCount = 0;
  int failCount = 0;

  sat_add_pipe #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .Cin(Cin),
    .acc(acc),
    .clr(clr),
`ifdef SAT_ADD_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Result(Result),
    .Cout(Cout),
    .ovf(ovf),
    .ovf_cnt(ovf_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One offered beat: drive operands, cross one rising edge, sample 1 time unit later.
  task automatic applyStimulus(input logic [3:0] va, input logic [3:0] vb, input logic vcin,
                               input logic vacc, input logic vclr);
    a        = va;
    b        = vb;
    Cin      = vcin;
    acc      = vacc;
    clr      = vclr;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  initial begin
    RST = 1'b1; in_valid = 1'b0; a = '0; b = '0; Cin = 1'b0;
    acc = 1'b0; clr = 1'b0; out_ready = 1'b1;
`ifdef SAT_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result", 32'(Result), 32'd0);
    checkOutput("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

    // Positive overflow saturates to max positive
    applyStimulus(4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0);
    checkOutput("pos_sat_valid", 32'(out_valid), 32'd1);
    checkOutput("pos_sat_result", 32'(Result), 32'h7);
    checkOutput("pos_sat_ovf", 32'(ovf), 32'd1);
    checkOutput("pos_sat_cout", 32'(Cout), 32'd0);
    checkOutput("pos_sat_cnt", 32'(ovf_cnt), 32'd1);
    @(posedge CLK); #1;
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_hold", 32'(Result), 32'h7);

    // Negative overflow saturates to min negative with carry out
    applyStimulus(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
    checkOutput("neg_sat_result", 32'(Result), 32'h8);
    checkOutput("neg_sat_ovf", 32'(ovf), 32'd1);
    checkOutput("neg_sat_cout", 32'(Cout), 32'd1);
    checkOutput("neg_sat_cnt", 32'(ovf_cnt), 32'd2);
    applyStimulus(4'b0011, 4'b0010, 1'b1, 1'b0, 1'b0);
    checkOutput("cin_sum_result", 32'(Result), 32'h6);
    checkOutput("cin_sum_ovf", 32'(ovf), 32'd0);
    checkOutput("cin_sum_cout", 32'(Cout), 32'd0);

    // Back-pressure: first beat (1+1) held, second beat (2+1) waits for release
    @(posedge CLK); #1;
    out_ready = 1'b0;
    a = 4'd1; b = 4'd1; Cin = 1'b0; acc = 1'b0; in_valid = 1'b1;
    @(posedge CLK); #1;
    a = 4'd2;
    checkOutput("bp_first_result", 32'(Result), 32'h2);
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(posedge CLK); #1;
      checkOutput("bp_stall_result", 32'(Result), 32'h2);
      checkOutput("bp_stall_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    checkOutput("bp_second_result", 32'(Result), 32'h3);
    checkOutput("bp_second_valid", 32'(out_valid), 32'd1);
    @(posedge CLK); #1;
    checkOutput("bp_no_dup", 32'(out_valid), 32'd0);
    checkOutput("bp_hold", 32'(Result), 32'h3);

    // Accumulator: clear, then 0+3=3, 3+3=6, 6+3 saturates to 7
    clr = 1'b1;
    @(posedge CLK); #1;
    clr = 1'b0;
    applyStimulus(4'b0000, 4'b0011, 1'b0, 1'b1, 1'b0);
    checkOutput("acc1_result", 32'(Result), 32'h3);
    checkOutput("acc1_ovf", 32'(ovf), 32'd0);
    applyStimulus(4'b0000, 4'b0011, 1'b0, 1'b1, 1'b0);
    checkOutput("acc2_result", 32'(Result), 32'h6);
    checkOutput("acc2_ovf", 32'(ovf), 32'd0);
    applyStimulus(4'b0000, 4'b0011, 1'b0, 1'b1, 1'b0);
    checkOutput("acc3_result", 32'(Result), 32'h7);
    checkOutput("acc3_ovf", 32'(ovf), 32'd1);
    // Clear with a transfer: beat uses old acc (7+1 saturates), next beat starts from 0
    applyStimulus(4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_xfer_result", 32'(Result), 32'h7);
    checkOutput("clr_xfer_ovf", 32'(ovf), 32'd1);
    applyStimulus(4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0);
    checkOutput("after_clr_result", 32'(Result), 32'h2);
    checkOutput("ovf_cnt_running", 32'(ovf_cnt), 32'd4);

    // Counter sticks at all-ones after many overflowing beats
    a = 4'b0111; b = 4'b0001; Cin = 1'b0; acc = 1'b0; in_valid = 1'b1;
    repeat (300) @(posedge CLK);
    #1;
    checkOutput("cnt_sticky", 32'(ovf_cnt), 32'd255);
    checkOutput("cnt_stream_valid", 32'(out_valid), 32'd1);

    // Reset mid-stream overrides the offered transfer and clr
    RST = 1'b1; clr = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; clr = 1'b0; in_valid = 1'b0;
    checkOutput("mid_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_result", 32'(Result), 32'd0);
    checkOutput("mid_rst_cout", 32'(Cout), 32'd0);
    checkOutput("mid_rst_ovf", 32'(ovf), 32'd0);
    checkOutput("mid_rst_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("mid_rst_ready", 32'(in_ready), 32'd1);
    applyStimulus(4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0);
    checkOutput("mid_rst_acc", 32'(Result), 32'h1);

`ifdef SAT_ADD_SUB_EN
    sub = 1'b1;
    applyStimulus(4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0);
    checkOutput("sub_sat_result", 32'(Result), 32'h8);
    checkOutput("sub_sat_ovf", 32'(ovf), 32'd1);
    applyStimulus(4'b0101, 4'b0011, 1'b0, 1'b0, 1'b0);
    checkOutput("sub_result", 32'(Result), 32'h2);
    checkOutput("sub_ovf", 32'(ovf), 32'd0);
    sub = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/sat_add_pipe.md
SAT_ADD_PIPE -- requirements
Module: sat_add_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, default 4, operand/result width in bits (legal 2..32).
REQ-002 SHALL have parameter: CNT_W, default 8, width of overflow event counter.
REQ-003 SHALL have port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: in_valid  input  1  operand beat offered.
REQ-006 SHALL have port: in_ready  output  1  block accepts beat this cycle.
REQ-007 SHALL have port: a  input  WIDTH  signed operand A.
REQ-008 SHALL have port: b  input  WIDTH  signed operand B.
REQ-009 SHALL have port: Cin  input  1  carry-in.
REQ-010 SHALL have port: acc  input  1  when 1, operand A replaced by accumulator register.
REQ-011 SHALL have port: clr  input  1  clear accumulator.
REQ-012 SHALL have port: out_valid  output  1  Result holds an unconsumed beat.
REQ-013 SHALL have port: out_ready  input  1  consumer takes beat.
REQ-014 SHALL have port: Result  output  WIDTH  saturated signed sum.
REQ-015 SHALL have port: Cout  output  1  raw carry out of MSB.
REQ-016 SHALL have port: ovf  output  1  Result was saturated.
REQ-017 SHALL have port: ovf_cnt  output  CNT_W  count of saturated beats.

Function
REQ-018 Operand A (opA) SHALL be acc_reg when acc=1, else a.
REQ-019 Raw sum SHALL be opA+b+Cin in WIDTH bits; overflow = carry into MSB XOR carry out of MSB.
REQ-020 On overflow, Result SHALL be max positive (0,1...1) if opA MSB=0, min negative (1,0...0) if opA MSB=1; else raw sum.
REQ-021 in_ready SHALL equal !out_valid || out_ready (combinational; one-entry output stage, states EMPTY/FULL).
REQ-022 Transfer SHALL occur when in_valid && in_ready; Result/Cout/ovf register on that edge, out_valid=1 next cycle (latency 1).
REQ-023 Simultaneous consume and accept SHALL keep out_valid=1 with new data, no bubble.
REQ-024 Consume without accept SHALL clear out_valid next cycle; Result/Cout/ovf hold last value.
REQ-025 While out_valid && !out_ready, Result/Cout/ovf SHALL stay stable.
REQ-026 acc_reg SHALL load the saturated Result on every transfer.
REQ-027 clr SHALL zero acc_reg next edge, taking priority over REQ-026; a transfer in the same cycle uses the pre-clear acc_reg and still outputs normally.
REQ-028 ovf_cnt SHALL increment on each transfer with overflow and stick at all-ones (no wrap).

Reset
REQ-029 On RST=1 at an edge: out_valid=0, Result=0, Cout=0, ovf=0, acc_reg=0, ovf_cnt=0; in-flight beat discarded.
REQ-030 in_ready SHALL be 1 the cycle after reset; RST overrides clr and transfers in the same cycle.

Configuration
REQ-031 With SAT_ADD_SUB_EN defined, SHALL add port sub (input, 1); when sub=1 compute opA + ~b + 1 (Cin ignored), saturation per REQ-019/020 on that sum.
REQ-032 Without SAT_ADD_SUB_EN, port sub SHALL not exist and the block always adds.

Verification (WIDTH=4, out_ready=1 unless stated)
REQ-033 a=0111,b=0001,Cin=0 -> Result=0111, ovf=1, Cout=0, ovf_cnt=1, out_valid one cycle later.
REQ-034 a=1000,b=1111,Cin=0 -> Result=1000, ovf=1, Cout=1; a=0011,b=0010,Cin=1 -> Result=0110, ovf=0.
REQ-035 out_ready=0 for 3 cycles with back-to-back in_valid -> first beat held stable, in_ready=0 after first transfer, no beat lost or duplicated on release.
REQ-036 clr, then acc=1,b=0011 for 3 beats -> Result 0011,0110,0111 with ovf=0,0,1; clr+transfer same cycle -> following acc beat starts from 0.
REQ-037 300 overflowing beats -> ovf_cnt=255 stuck; RST mid-stream with out_valid=1 -> all outputs 0 next cycle, in_ready=1.
REQ-038 With SAT_ADD_SUB_EN: a=1000,b=0001,sub=1 -> Result=1000, ovf=1; a=0101,b=0011,sub=1 -> Result=0010, ovf=0.
